// File: rtl/expr_check.sv
// ============================================================================
// Module   : expr_check
// Purpose  : Streaming syntax checker for ASCII arithmetic expressions.
//            Accepts one character per clock while in_valid is high and tracks
//            operand length, parenthesis nesting and operator placement.
//            The terminator '=' produces a one-cycle done pulse carrying the
//            verdict for the expression, then restarts the checker.
// Ports    : clk      - clock, rising edge
//            clr_n    - asynchronous active-low reset
//            in       - ASCII character, sampled when in_valid=1
//            in_valid - character strobe; 0 holds all state
//            out      - accepted characters form a complete legal expression
//            err      - sticky error flag for the current expression
//            depth    - current open-parenthesis count
//            done     - one-cycle pulse after '=' is accepted
//            done_ok  - verdict for the terminated expression (valid with done)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module expr_check #(
    parameter int MAX_DIGITS = 4,   // 1..15
    parameter int MAX_DEPTH  = 3,   // 1..15
    parameter int OP_EXT     = 0    // 1 enables '-' and '/'
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic [7:0] in,
    input  logic       in_valid,
    output logic       out,
    output logic       err,
    output logic [3:0] depth,
    output logic       done,
    output logic       done_ok
);

    localparam logic [3:0] c_MAX_DIGITS = 4'(MAX_DIGITS);
    localparam logic [3:0] c_MAX_DEPTH  = 4'(MAX_DEPTH);

    typedef enum logic [2:0] {
        S_START = 3'd0,
        S_NUM   = 3'd1,
        S_OPER  = 3'd2,
        S_CLOSE = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    state_t     r_state;
    logic [3:0] r_depth;
    logic [3:0] r_count;
    logic       r_err;
    logic       r_done;
    logic       r_done_ok;

    // Character classification
    logic w_digit;
    logic w_op;
    logic w_open;
    logic w_close;
    logic w_term;
    logic w_complete;

    assign w_digit = (in >= 8'h30) && (in <= 8'h39);
    assign w_op    = (in == 8'h2B) || (in == 8'h2A) ||
                     ((OP_EXT != 0) && ((in == 8'h2D) || (in == 8'h2F)));
    assign w_open  = (in == 8'h28);
    assign w_close = (in == 8'h29);
    assign w_term  = (in == 8'h3D);

    // A prefix is a complete expression when it ends on an operand or a
    // closing parenthesis with every parenthesis matched and no error seen.
    assign w_complete = ((r_state == S_NUM) || (r_state == S_CLOSE)) &&
                        (r_depth == 4'd0) && !r_err;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state   <= S_START;
            r_depth   <= 4'd0;
            r_count   <= 4'd0;
            r_err     <= 1'b0;
            r_done    <= 1'b0;
            r_done_ok <= 1'b0;
        end else begin
            // done/done_ok are single-cycle pulses; a back-to-back '='
            // re-asserts them below.
            r_done    <= 1'b0;
            r_done_ok <= 1'b0;
            if (in_valid) begin
                if (w_term) begin
                    r_done    <= 1'b1;
                    r_done_ok <= w_complete;
                    r_state   <= S_START;
                    r_depth   <= 4'd0;
                    r_count   <= 4'd0;
                    r_err     <= 1'b0;
                end else begin
                    case (r_state)
                        S_START, S_OPER: begin
                            if (w_digit) begin
                                r_state <= S_NUM;
                                r_count <= 4'd1;
                            end else if (w_open && (r_depth < c_MAX_DEPTH)) begin
                                r_state <= S_OPER;
                                r_depth <= r_depth + 4'd1;
                            end else begin
                                r_state <= S_ERROR;
                                r_err   <= 1'b1;
                            end
                        end
                        S_NUM: begin
                            if (w_digit && (r_count < c_MAX_DIGITS)) begin
                                r_count <= r_count + 4'd1;
                            end else if (w_op) begin
                                r_state <= S_OPER;
                            end else if (w_close && (r_depth != 4'd0)) begin
                                r_state <= S_CLOSE;
                                r_depth <= r_depth - 4'd1;
                            end else begin
                                r_state <= S_ERROR;
                                r_err   <= 1'b1;
                            end
                        end
                        S_CLOSE: begin
                            if (w_op) begin
                                r_state <= S_OPER;
                            end else if (w_close && (r_depth != 4'd0)) begin
                                r_depth <= r_depth - 4'd1;
                            end else begin
                                r_state <= S_ERROR;
                                r_err   <= 1'b1;
                            end
                        end
                        default: begin
                            // ERROR absorbs everything until the terminator.
                            r_state <= S_ERROR;
                        end
                    endcase
                end
            end
        end
    end

    assign out     = w_complete;
    assign err     = r_err;
    assign depth   = r_depth;
    assign done    = r_done;
    assign done_ok = r_done_ok;

endmodule

`default_nettype wire
